mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the IF stage (fetch, read-only) and the MEM stage
//  (lw/sw). Sequences the variable-latency bus handshake and emits per-stage stall requests

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : IF/MEM requester ports and shared memory bus of mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_stall;

    logic                  bus_req;
    logic                  bus_we;
    logic [DATA_W/8-1:0]   bus_be;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_ready;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_stall,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_stall,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    // Pipeline stages plus memory side
    modport master (
        output if_req, if_addr,
        input  if_rdata, if_stall,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between IF (fetch) and MEM (lw/sw),
//            MEM has fixed priority. Optional MEM_ARB_PERF_CNT_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  wire               clk,
    input  wire               rst_n,
    mem_port_arbiter_if.slave bus_if
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    input  wire               perf_clr,
    output logic [CNT_W-1:0]  perf_if_wait,
    output logic [CNT_W-1:0]  perf_mem_wait,
    output logic [CNT_W-1:0]  perf_conflict
`endif
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_IF_BUSY  = 2'd1;
    localparam logic [1:0] c_MEM_BUSY = 2'd2;

    logic [1:0]        r_state;
    logic              r_we;
    logic [BE_W-1:0]   r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_idle;
    logic              w_pick_mem;
    logic              w_pick_if;
    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_if_stall;
    logic              w_mem_stall;
    logic              w_cmd_we;
    logic [BE_W-1:0]   w_cmd_be;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [DATA_W-1:0] w_cmd_wdata;

    assign w_idle      = (r_state == c_IDLE);
    assign w_pick_mem  = bus_if.mem_req;
    assign w_pick_if   = !bus_if.mem_req && bus_if.if_req;
    assign w_grant_mem = rst_n && ((w_idle && w_pick_mem) || (r_state == c_MEM_BUSY));
    assign w_grant_if  = rst_n && ((w_idle && w_pick_if)  || (r_state == c_IF_BUSY));
    assign w_if_stall  = rst_n && bus_if.if_req  && !(w_grant_if  && bus_if.bus_ready);
    assign w_mem_stall = rst_n && bus_if.mem_req && !(w_grant_mem && bus_if.bus_ready);

    // Command of the IDLE-state winner; loads always read the full word.
    always_comb begin
        w_cmd_we    = 1'b0;
        w_cmd_be    = '0;
        w_cmd_addr  = '0;
        w_cmd_wdata = '0;
        if (w_pick_mem) begin
            w_cmd_we    = bus_if.mem_we;
            w_cmd_be    = bus_if.mem_we ? bus_if.mem_be : '1;
            w_cmd_addr  = bus_if.mem_addr;
            w_cmd_wdata = bus_if.mem_wdata;
        end else if (w_pick_if) begin
            w_cmd_be    = '1;
            w_cmd_addr  = bus_if.if_addr;
        end
    end

    always_comb begin
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_be    = '0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        if (rst_n) begin
            if (w_idle) begin
                bus_if.bus_req   = w_pick_mem || w_pick_if;
                bus_if.bus_we    = w_cmd_we;
                bus_if.bus_be    = w_cmd_be;
                bus_if.bus_addr  = w_cmd_addr;
                bus_if.bus_wdata = w_cmd_wdata;
            end else begin
                bus_if.bus_req   = 1'b1;
                bus_if.bus_we    = r_we;
                bus_if.bus_be    = r_be;
                bus_if.bus_addr  = r_addr;
                bus_if.bus_wdata = r_wdata;
            end
        end
    end

    assign bus_if.if_stall  = w_if_stall;
    assign bus_if.mem_stall = w_mem_stall;
    assign bus_if.if_rdata  = w_grant_if  ? bus_if.bus_rdata : '0;
    assign bus_if.mem_rdata = w_grant_mem ? bus_if.bus_rdata : '0;

    // A started transfer always runs to bus_ready, even if its requester withdraws.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if ((w_pick_mem || w_pick_if) && !bus_if.bus_ready) begin
                        r_we    <= w_cmd_we;
                        r_be    <= w_cmd_be;
                        r_addr  <= w_cmd_addr;
                        r_wdata <= w_cmd_wdata;
                        r_state <= w_pick_mem ? c_MEM_BUSY : c_IF_BUSY;
                    end
                end
                c_IF_BUSY, c_MEM_BUSY: begin
                    if (bus_if.bus_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] r_if_wait;
    logic [CNT_W-1:0] r_mem_wait;
    logic [CNT_W-1:0] r_conflict;
    logic             w_conflict;

    assign w_conflict    = w_idle && bus_if.if_req && bus_if.mem_req;
    assign perf_if_wait  = r_if_wait;
    assign perf_mem_wait = r_mem_wait;
    assign perf_conflict = r_conflict;

    // Saturating counters; clear takes precedence over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_wait  <= '0;
            r_mem_wait <= '0;
            r_conflict <= '0;
        end else if (perf_clr) begin
            r_if_wait  <= '0;
            r_mem_wait <= '0;
            r_conflict <= '0;
        end else begin
            if (w_if_stall && (r_if_wait != '1)) begin
                r_if_wait <= r_if_wait + CNT_W'(1);
            end
            if (w_mem_stall && (r_mem_wait != '1)) begin
                r_mem_wait <= r_mem_wait + CNT_W'(1);
            end
            if (w_conflict && (r_conflict != '1)) begin
                r_conflict <= r_conflict + CNT_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic       perf_clr;
    logic [3:0] perf_if_wait;
    logic [3:0] perf_mem_wait;
    logic [3:0] perf_conflict;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_if        (ifc.slave),
        .perf_clr      (perf_clr),
        .perf_if_wait  (perf_if_wait),
        .perf_mem_wait (perf_mem_wait),
        .perf_conflict (perf_conflict)
    );
`else
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifc.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.if_req    = 1'b0;
        ifc.if_addr   = '0;
        ifc.mem_req   = 1'b0;
        ifc.mem_we    = 1'b0;
        ifc.mem_be    = '0;
        ifc.mem_addr  = '0;
        ifc.mem_wdata = '0;
        ifc.bus_rdata = '0;
        ifc.bus_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.if_req = 1'b1; ifc.if_addr = 32'h10;
        ifc.mem_req = 1'b1; ifc.mem_addr = 32'h20;
        ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'hFFFF_FFFF;
        #2;
        checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %b exp 0", ifc.bus_req); end
        checks++; if (ifc.bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr got %h exp 0", ifc.bus_addr); end
        checks++; if (ifc.bus_be !== 4'h0) begin errors++; $display("FAIL rst_bus_be got %h exp 0", ifc.bus_be); end
        checks++; if (ifc.if_stall !== 1'b0 || ifc.mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stalls got %b%b exp 00", ifc.if_stall, ifc.mem_stall); end
        checks++; if (ifc.mem_rdata !== 32'h0 || ifc.if_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", ifc.if_rdata, ifc.mem_rdata); end
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++; if (dut.r_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dut.r_state); end
        checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL idle_bus_req got %b exp 0", ifc.bus_req); end
    endtask

    task automatic test_if_zero_wait();
        next_cycle();
        ifc.if_req = 1'b1; ifc.if_addr = 32'h0000_0040;
        ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'h1234_5678;
        #1;
        checks++; if (ifc.bus_req !== 1'b1) begin errors++; $display("FAIL t1_bus_req got %b exp 1", ifc.bus_req); end
        checks++; if (ifc.bus_addr !== 32'h40) begin errors++; $display("FAIL t1_bus_addr got %h exp 40", ifc.bus_addr); end
        checks++; if (ifc.bus_we !== 1'b0 || ifc.bus_be !== 4'hF) begin errors++; $display("FAIL t1_cmd got we=%b be=%h exp we=0 be=f", ifc.bus_we, ifc.bus_be); end
        checks++; if (ifc.if_stall !== 1'b0) begin errors++; $display("FAIL t1_if_stall got %b exp 0", ifc.if_stall); end
        checks++; if (ifc.if_rdata !== 32'h1234_5678) begin errors++; $display("FAIL t1_if_rdata got %h exp 12345678", ifc.if_rdata); end
        next_cycle();
        checks++; if (dut.r_state !== 2'd0) begin errors++; $display("FAIL t1_state got %0d exp 0", dut.r_state); end
        ifc.if_req = 1'b0;
    endtask

    task automatic test_priority();
        next_cycle();
        ifc.if_req = 1'b1; ifc.if_addr = 32'h80;
        ifc.mem_req = 1'b1; ifc.mem_we = 1'b0; ifc.mem_be = 4'h0; ifc.mem_addr = 32'h100;
        ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'hA5A5_0001;
        #1;
        checks++; if (ifc.bus_addr !== 32'h100) begin errors++; $display("FAIL t2_c0_bus_addr got %h exp 100", ifc.bus_addr); end
        checks++; if (ifc.bus_be !== 4'hF) begin errors++; $display("FAIL t2_load_be got %h exp f", ifc.bus_be); end
        checks++; if (ifc.mem_stall !== 1'b0 || ifc.if_stall !== 1'b1) begin errors++; $display("FAIL t2_c0_stalls got mem=%b if=%b exp mem=0 if=1", ifc.mem_stall, ifc.if_stall); end
        checks++; if (ifc.mem_rdata !== 32'hA5A5_0001 || ifc.if_rdata !== 32'h0) begin errors++; $display("FAIL t2_c0_rdata got mem=%h if=%h exp a5a50001/0", ifc.mem_rdata, ifc.if_rdata); end
        next_cycle();
        ifc.mem_req = 1'b0; ifc.bus_rdata = 32'hC0DE_0002;
        #1;
        checks++; if (ifc.bus_addr !== 32'h80) begin errors++; $display("FAIL t2_c1_bus_addr got %h exp 80", ifc.bus_addr); end
        checks++; if (ifc.if_stall !== 1'b0) begin errors++; $display("FAIL t2_c1_if_stall got %b exp 0", ifc.if_stall); end
        checks++; if (ifc.if_rdata !== 32'hC0DE_0002) begin errors++; $display("FAIL t2_c1_if_rdata got %h exp c0de0002", ifc.if_rdata); end
        ifc.if_req = 1'b0;
    endtask

    task automatic test_store_wait();
        next_cycle();
        ifc.mem_req = 1'b1; ifc.mem_we = 1'b1; ifc.mem_addr = 32'h200;
        ifc.mem_wdata = 32'hDEAD_BEEF; ifc.mem_be = 4'b0011; ifc.bus_ready = 1'b0;
        #1;
        checks++; if (ifc.bus_addr !== 32'h200 || ifc.bus_we !== 1'b1 || ifc.bus_be !== 4'b0011) begin errors++; $display("FAIL t3_c1_cmd got %h we=%b be=%h exp 200 1 3", ifc.bus_addr, ifc.bus_we, ifc.bus_be); end
        checks++; if (ifc.mem_stall !== 1'b1) begin errors++; $display("FAIL t3_c1_stall got %b exp 1", ifc.mem_stall); end
        next_cycle();
        ifc.mem_addr = 32'h300; ifc.mem_wdata = 32'h0; ifc.mem_be = 4'hF;
        #1;
        checks++; if (dut.r_state !== 2'd2) begin errors++; $display("FAIL t3_state got %0d exp 2", dut.r_state); end
        checks++; if (ifc.bus_addr !== 32'h200 || ifc.bus_wdata !== 32'hDEAD_BEEF || ifc.bus_be !== 4'b0011) begin errors++; $display("FAIL t3_c2_cmd got %h %h %h exp 200 deadbeef 3", ifc.bus_addr, ifc.bus_wdata, ifc.bus_be); end
        checks++; if (ifc.mem_stall !== 1'b1) begin errors++; $display("FAIL t3_c2_stall got %b exp 1", ifc.mem_stall); end
        next_cycle();
        checks++; if (ifc.mem_stall !== 1'b1 || ifc.bus_req !== 1'b1) begin errors++; $display("FAIL t3_c3 got stall=%b req=%b exp 1 1", ifc.mem_stall, ifc.bus_req); end
        next_cycle();
        ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'h0BAD_F00D;
        ifc.if_req = 1'b1; ifc.if_addr = 32'h84;
        #1;
        checks++; if (ifc.mem_stall !== 1'b0) begin errors++; $display("FAIL t3_c4_stall got %b exp 0", ifc.mem_stall); end
        checks++; if (ifc.bus_addr !== 32'h200 || ifc.if_stall !== 1'b1) begin errors++; $display("FAIL t3_no_b2b got addr=%h if_stall=%b exp 200 1", ifc.bus_addr, ifc.if_stall); end
        checks++; if (ifc.if_rdata !== 32'h0) begin errors++; $display("FAIL t3_if_rdata got %h exp 0", ifc.if_rdata); end
        next_cycle();
        ifc.mem_req = 1'b0; ifc.mem_we = 1'b0;
        #1;
        checks++; if (dut.r_state !== 2'd0) begin errors++; $display("FAIL t3_ret_state got %0d exp 0", dut.r_state); end
        checks++; if (ifc.bus_addr !== 32'h84 || ifc.if_stall !== 1'b0) begin errors++; $display("FAIL t3_if_after got addr=%h stall=%b exp 84 0", ifc.bus_addr, ifc.if_stall); end
        ifc.if_req = 1'b0;
    endtask

    task automatic test_flush();
        next_cycle();
        ifc.if_req = 1'b1; ifc.if_addr = 32'h44; ifc.bus_ready = 1'b0;
        #1;
        checks++; if (ifc.if_stall !== 1'b1) begin errors++; $display("FAIL t4_stall got %b exp 1", ifc.if_stall); end
        next_cycle();
        ifc.if_req = 1'b0; ifc.if_addr = 32'h0;
        #1;
        checks++; if (dut.r_state !== 2'd1) begin errors++; $display("FAIL t4_state got %0d exp 1", dut.r_state); end
        checks++; if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h44) begin errors++; $display("FAIL t4_held got req=%b addr=%h exp 1 44", ifc.bus_req, ifc.bus_addr); end
        checks++; if (ifc.if_stall !== 1'b0) begin errors++; $display("FAIL t4_nostall got %b exp 0", ifc.if_stall); end
        next_cycle();
        ifc.bus_ready = 1'b1;
        #1;
        checks++; if (ifc.bus_req !== 1'b1) begin errors++; $display("FAIL t4_done_req got %b exp 1", ifc.bus_req); end
        next_cycle();
        ifc.bus_ready = 1'b0;
        #1;
        checks++; if (dut.r_state !== 2'd0 || ifc.bus_req !== 1'b0) begin errors++; $display("FAIL t4_idle got state=%0d req=%b exp 0 0", dut.r_state, ifc.bus_req); end
    endtask

    task automatic test_async_reset();
        next_cycle();
        ifc.mem_req = 1'b1; ifc.mem_we = 1'b0; ifc.mem_addr = 32'h300; ifc.bus_ready = 1'b0;
        next_cycle();
        checks++; if (dut.r_state !== 2'd2) begin errors++; $display("FAIL t5_busy got %0d exp 2", dut.r_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (ifc.bus_req !== 1'b0 || ifc.mem_stall !== 1'b0) begin errors++; $display("FAIL t5_rst got req=%b stall=%b exp 0 0", ifc.bus_req, ifc.mem_stall); end
        checks++; if (dut.r_state !== 2'd0) begin errors++; $display("FAIL t5_rst_state got %0d exp 0", dut.r_state); end
        ifc.mem_addr = 32'h304; ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'h5555_AAAA;
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (ifc.bus_addr !== 32'h304 || ifc.mem_stall !== 1'b0) begin errors++; $display("FAIL t5_after got addr=%h stall=%b exp 304 0", ifc.bus_addr, ifc.mem_stall); end
        checks++; if (ifc.mem_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL t5_rdata got %h exp 5555aaaa", ifc.mem_rdata); end
        next_cycle();
        clear_inputs();
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf();
        next_cycle();
        ifc.if_req = 1'b1; ifc.if_addr = 32'h8;
        ifc.mem_req = 1'b1; ifc.mem_addr = 32'hC; ifc.bus_ready = 1'b1;
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        checks++; if (perf_conflict !== 4'd0 || perf_if_wait !== 4'd0) begin errors++; $display("FAIL t6_clr0 got %0d/%0d exp 0/0", perf_conflict, perf_if_wait); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (perf_conflict !== 4'd3) begin errors++; $display("FAIL t6_conf3 got %0d exp 3", perf_conflict); end
        checks++; if (perf_if_wait !== 4'd3 || perf_mem_wait !== 4'd0) begin errors++; $display("FAIL t6_wait got if=%0d mem=%0d exp 3 0", perf_if_wait, perf_mem_wait); end
        repeat (17) @(posedge clk);
        #1;
        checks++; if (perf_conflict !== 4'd15 || perf_if_wait !== 4'd15) begin errors++; $display("FAIL t6_sat got %0d/%0d exp 15/15", perf_conflict, perf_if_wait); end
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        checks++; if (perf_conflict !== 4'd0 || perf_if_wait !== 4'd0) begin errors++; $display("FAIL t6_clr got %0d/%0d exp 0/0", perf_conflict, perf_if_wait); end
        clear_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        clear_inputs();
        test_reset();
        test_if_zero_wait();
        test_priority();
        test_store_wait();
        test_flush();
        test_async_reset();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
